// File: rtl/mem_lsu_ctrl_if.sv
// Request/response and SRAM signal bundle for the MEM-stage load/store controller.
// slave = controller side, master = pipeline side, sram = data memory side.
interface mem_lsu_ctrl_if #(
  parameter int unsigned DEPTH_W = 10
);
  logic                req_valid;
  logic                req_wr;
  logic [31:0]         req_addr;
  logic [31:0]         req_wdata;
  logic [1:0]          req_be_op;
  logic [2:0]          req_ld_op;
  logic                stall;
  logic                resp_valid;
  logic [31:0]         resp_rdata;
  logic                misalign;
  logic                mem_en;
  logic [3:0]          mem_we;
  logic [DEPTH_W-1:0]  mem_addr;
  logic [31:0]         mem_wdata;
  logic [31:0]         mem_rdata;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_be_op, req_ld_op, mem_rdata,
    output stall, resp_valid, resp_rdata, misalign, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_be_op, req_ld_op,
    input  stall, resp_valid, resp_rdata, misalign
  );

  modport sram (
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_lsu_ctrl.sv
// MEM-stage load/store controller: byte-lane stores, latency-stalled loads with
// alignment check and sign/zero extension of the returned data.
module mem_lsu_ctrl #(
  parameter int unsigned DEPTH_W = 10,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic           clk,
  input  logic           rst,
  mem_lsu_ctrl_if.slave  bus
);
  localparam int unsigned CNT_W = 2;

  typedef enum logic {IDLE, RD_WAIT} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         off_q, off_d;
  logic [2:0]         op_q, op_d;

  logic               is_byte, is_half, mis_c;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [31:0]        ld_data;
  logic               unused_addr_c;

  assign unused_addr_c = ^bus.req_addr[31:DEPTH_W+2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      off_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      op_q    <= op_d;
    end
  end

  // Access size: stores decode be_op, loads decode ld_op; anything else is a word.
  always_comb begin
    is_byte = 1'b0;
    is_half = 1'b0;
    if (bus.req_wr) begin
      is_byte = (bus.req_be_op == 2'b11);
      is_half = (bus.req_be_op == 2'b10);
    end else begin
      is_byte = (bus.req_ld_op == 3'b001) || (bus.req_ld_op == 3'b010);
      is_half = (bus.req_ld_op == 3'b011) || (bus.req_ld_op == 3'b100);
    end
    mis_c = (is_half && bus.req_addr[0]) ||
            (!is_byte && !is_half && (bus.req_addr[1:0] != 2'b00));
  end

  // Lane extraction and extension from the latched offset/op.
  always_comb begin
    ld_byte = 8'h00;
    case (off_q)
      2'd0:    ld_byte = bus.mem_rdata[7:0];
      2'd1:    ld_byte = bus.mem_rdata[15:8];
      2'd2:    ld_byte = bus.mem_rdata[23:16];
      default: ld_byte = bus.mem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (op_q)
      3'b001:  ld_data = {24'h000000, ld_byte};
      3'b010:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b011:  ld_data = {16'h0000, ld_half};
      3'b100:  ld_data = {{16{ld_half[15]}}, ld_half};
      default: ld_data = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    off_d          = off_q;
    op_d           = op_q;
    bus.stall      = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = 32'h0;
    bus.misalign   = 1'b0;
    bus.mem_en     = 1'b0;
    bus.mem_we     = 4'b0000;
    bus.mem_addr   = '0;
    bus.mem_wdata  = 32'h0;
    case (state_q)
      IDLE: begin
        // Gating on rst keeps every output quiet while reset is held.
        if (bus.req_valid && !rst) begin
          if (mis_c) begin
            bus.misalign = 1'b1;
          end else begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.req_addr[DEPTH_W+1:2];
            if (bus.req_wr) begin
              if (is_byte) begin
                bus.mem_we    = 4'(4'b0001 << bus.req_addr[1:0]);
                bus.mem_wdata = {4{bus.req_wdata[7:0]}};
              end else if (is_half) begin
                bus.mem_we    = 4'(4'b0011 << bus.req_addr[1:0]);
                bus.mem_wdata = {2{bus.req_wdata[15:0]}};
              end else begin
                bus.mem_we    = 4'b1111;
                bus.mem_wdata = bus.req_wdata;
              end
            end else begin
              bus.stall = 1'b1;
              state_d   = RD_WAIT;
              cnt_d     = CNT_W'(RD_LAT - 1);
              off_d     = bus.req_addr[1:0];
              op_d      = bus.req_ld_op;
            end
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d     = cnt_q - 1'b1;
          bus.stall = 1'b1;
        end else begin
          bus.resp_valid = 1'b1;
          bus.resp_rdata = ld_data;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
